// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arb_pkg
//  Description : Shared widths and requester encoding for the register-file
//                write-back arbiter and its scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;

  // Which write-back source owns the register-file port
  typedef enum logic [0:0] {
    REQ_MEM = 1'b0,
    REQ_ALU = 1'b1
  } req_e;

endpackage
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : wb_scoreboard
//  Description : One busy bit per destination register. A claim sets the bit,
//                a retired write clears it; a claim and a retirement on the
//                same register at the same edge leave the bit set, because the
//                new claim is still outstanding.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_scoreboard #(
  parameter int ADDR_W   = wb_arb_pkg::ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_set_en,
  input  logic [ADDR_W-1:0]   i_set_addr,
  input  logic                i_clr_en,
  input  logic [ADDR_W-1:0]   i_clr_addr,
  output logic [NUM_REGS-1:0] o_busy
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;

  // Decode the claim and retirement addresses into one-hot masks
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set_en) w_set_mask[i_set_addr] = 1'b1;
    if (i_clr_en) w_clr_mask[i_clr_addr] = 1'b1;
  end

  // Clear first, then OR in the set so a same-edge claim survives
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
    end
  end

  assign o_busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Shares the register file's single write port between the
//                memory-load and ALU write-back paths, registers the winning
//                write, and tracks outstanding destinations for hazard stalls.
//                Build option WB_ARB_RR_EN selects round-robin arbitration;
//                otherwise memory has priority with an ALU starvation limit.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DATA_W     = wb_arb_pkg::DATA_W,
  parameter int ADDR_W     = wb_arb_pkg::ADDR_W,
  parameter int STARVE_MAX = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_valid,
  input  logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   mem_ready,
  input  logic                   alu_valid,
  input  logic [ADDR_W-1:0]      alu_addr,
  input  logic [DATA_W-1:0]      alu_data,
  output logic                   alu_ready,
  input  logic                   claim_valid,
  input  logic [ADDR_W-1:0]      claim_addr,
  output logic                   rf_wr_en,
  output logic [ADDR_W-1:0]      rf_wr_addr,
  output logic [DATA_W-1:0]      rf_wr_data,
  output logic [2**ADDR_W-1:0]   busy_mask
);

  import wb_arb_pkg::*;

  localparam int c_NUM_REGS = 2 ** ADDR_W;

  logic              w_mem_wins;
  logic              w_xfer;
  req_e              w_winner;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

`ifdef WB_ARB_RR_EN
  req_e r_last;

  // On conflict the requester that was not granted last goes first
  always_comb begin
    w_mem_wins = (r_last == REQ_ALU);
  end

  // Pointer follows completed transfers only
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= REQ_MEM;
    end else if (w_xfer) begin
      r_last <= w_winner;
    end
  end
`else
  localparam int c_CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);

  logic [c_CNT_W-1:0] r_starve_cnt;

  // Memory keeps priority unless the ALU has lost STARVE_MAX times in a row
  always_comb begin
    w_mem_wins = !(alu_valid && (r_starve_cnt == c_STARVE_MAX));
  end

  // Count consecutive ALU losses; any ALU grant or idle ALU restarts the count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (!alu_valid || alu_ready) begin
      r_starve_cnt <= '0;
    end else if (mem_ready && (r_starve_cnt != c_STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`endif

  // Grant at most one requester, never without its valid, never in reset
  always_comb begin
    mem_ready = 1'b0;
    alu_ready = 1'b0;
    if (!reset) begin
      if (mem_valid && (!alu_valid || w_mem_wins)) begin
        mem_ready = 1'b1;
      end else if (alu_valid) begin
        alu_ready = 1'b1;
      end
    end
  end

  assign w_xfer   = mem_ready | alu_ready;
  assign w_winner = alu_ready ? REQ_ALU : REQ_MEM;

  // Write stage: capture the winner; address/data hold when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_xfer;
      if (w_xfer) begin
        if (w_winner == REQ_ALU) begin
          r_wr_addr <= alu_addr;
          r_wr_data <= alu_data;
        end else begin
          r_wr_addr <= mem_addr;
          r_wr_data <= mem_data;
        end
      end
    end
  end

  assign rf_wr_en   = r_wr_en;
  assign rf_wr_addr = r_wr_addr;
  assign rf_wr_data = r_wr_data;

  // Retirement is the write actually presented to the register file
  wb_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (c_NUM_REGS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (reset),
    .i_set_en   (claim_valid),
    .i_set_addr (claim_addr),
    .i_clr_en   (r_wr_en),
    .i_clr_addr (r_wr_addr),
    .o_busy     (busy_mask)
  );

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Directed self-checking bench for regfile_wb_arbiter.
//                Arbitration expectations follow WB_ARB_RR_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [3:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        alu_valid;
  logic [3:0]  alu_addr;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        claim_valid;
  logic [3:0]  claim_addr;
  logic        rf_wr_en;
  logic [3:0]  rf_wr_addr;
  logic [15:0] rf_wr_data;
  logic [15:0] busy_mask;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .DATA_W     (16),
    .ADDR_W     (4),
    .STARVE_MAX (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .alu_valid   (alu_valid),
    .alu_addr    (alu_addr),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .busy_mask   (busy_mask)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat;
    logic [6:0] av;
    logic [6:0] ea;
    logic       b;

`ifdef WB_ARB_RR_EN
    pat = 8'b0101_0101;   // A, M, A, M ... (bit0 first)
`else
    pat = 8'b1000_1000;   // M, M, M, A, M, M, M, A
`endif

    // ---------------- reset with both requesters asking ----------------
    reset = 1'b1; claim_valid = 1'b0; claim_addr = 4'h0;
    mem_valid = 1'b1; mem_addr = 4'h3; mem_data = 16'h1111;
    alu_valid = 1'b1; alu_addr = 4'h7; alu_data = 16'h2222;
    tick(); tick(); #1;
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd0);
    chk("rst_wr_en",     32'(rf_wr_en),  32'd0);
    chk("rst_wr_addr",   32'(rf_wr_addr), 32'd0);
    chk("rst_wr_data",   32'(rf_wr_data), 32'd0);
    chk("rst_busy",      32'(busy_mask), 32'h0000);

    // ---------------- continuous contention ----------------
    reset = 1'b0; #1;
    for (int i = 0; i < 8; i++) begin
      b = pat[i];
      chk($sformatf("cont_mem_ready[%0d]", i), 32'(mem_ready), 32'(!b));
      chk($sformatf("cont_alu_ready[%0d]", i), 32'(alu_ready), 32'(b));
      tick(); #1;
      chk($sformatf("cont_wr_en[%0d]", i),   32'(rf_wr_en), 32'd1);
      chk($sformatf("cont_wr_addr[%0d]", i), 32'(rf_wr_addr), b ? 32'h7 : 32'h3);
      chk($sformatf("cont_wr_data[%0d]", i), 32'(rf_wr_data), b ? 32'h2222 : 32'h1111);
    end

    // ---------------- idle: no grant, write port holds ----------------
    mem_valid = 1'b0; alu_valid = 1'b0; #1;
    chk("idle_mem_ready", 32'(mem_ready), 32'd0);
    chk("idle_alu_ready", 32'(alu_ready), 32'd0);
    tick(); #1;
    chk("idle_wr_en",   32'(rf_wr_en), 32'd0);
    chk("idle_wr_addr", 32'(rf_wr_addr), pat[7] ? 32'h7 : 32'h3);
    chk("idle_wr_data", 32'(rf_wr_data), pat[7] ? 32'h2222 : 32'h1111);

    // ---------------- memory alone ----------------
    mem_valid = 1'b1; mem_addr = 4'h2; mem_data = 16'hFFFF; #1;
    chk("mem_only_mem_ready", 32'(mem_ready), 32'd1);
    chk("mem_only_alu_ready", 32'(alu_ready), 32'd0);
    tick();
    mem_valid = 1'b0; #1;
    chk("mem_only_wr_en",   32'(rf_wr_en), 32'd1);
    chk("mem_only_wr_addr", 32'(rf_wr_addr), 32'h2);
    chk("mem_only_wr_data", 32'(rf_wr_data), 32'hFFFF);

`ifndef WB_ARB_RR_EN
    // ---------------- starvation count restarts when ALU goes idle ----------------
    av = 7'b111_1011;    // ALU valid per cycle, bit0 first
    ea = 7'b100_0000;    // ALU wins only on the last cycle
    mem_valid = 1'b1; alu_addr = 4'h7; alu_data = 16'h2222;
    for (int i = 0; i < 7; i++) begin
      alu_valid = av[i]; #1;
      chk($sformatf("starve_alu_ready[%0d]", i), 32'(alu_ready), 32'(ea[i]));
      chk($sformatf("starve_mem_ready[%0d]", i), 32'(mem_ready), 32'(!ea[i]));
      tick();
    end
    mem_valid = 1'b0; alu_valid = 1'b0;
    tick();
`endif
    tick();

    // ---------------- claim 1, ALU writes 1 in cycle 3 ----------------
    claim_valid = 1'b1; claim_addr = 4'h1; #1;
    chk("sb_c0_busy", 32'(busy_mask), 32'h0000);
    tick();
    claim_valid = 1'b0; #1;
    chk("sb_c1_busy", 32'(busy_mask), 32'h0002);
    tick(); #1;
    chk("sb_c2_busy", 32'(busy_mask), 32'h0002);
    tick();
    alu_valid = 1'b1; alu_addr = 4'h1; alu_data = 16'hABCD; #1;
    chk("sb_c3_alu_ready", 32'(alu_ready), 32'd1);
    chk("sb_c3_busy", 32'(busy_mask), 32'h0002);
    tick();
    alu_valid = 1'b0; #1;
    chk("sb_c4_busy",    32'(busy_mask), 32'h0002);
    chk("sb_c4_wr_en",   32'(rf_wr_en), 32'd1);
    chk("sb_c4_wr_addr", 32'(rf_wr_addr), 32'h1);
    chk("sb_c4_wr_data", 32'(rf_wr_data), 32'hABCD);
    tick(); #1;
    chk("sb_c5_busy", 32'(busy_mask), 32'h0000);

    // ---------------- same-edge claim and retirement on 5 ----------------
    claim_valid = 1'b1; claim_addr = 4'h5;
    tick();
    claim_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 4'h5; alu_data = 16'h5555; #1;
    chk("sw_c1_busy", 32'(busy_mask), 32'h0020);
    tick();
    alu_valid = 1'b0;
    claim_valid = 1'b1; claim_addr = 4'h5; #1;
    chk("sw_c2_wr_en",   32'(rf_wr_en), 32'd1);
    chk("sw_c2_wr_addr", 32'(rf_wr_addr), 32'h5);
    tick();
    claim_valid = 1'b0;
    alu_valid = 1'b1; alu_data = 16'h5A5A; #1;
    chk("sw_set_wins_busy", 32'(busy_mask), 32'h0020);
    tick();
    alu_valid = 1'b0; #1;
    chk("sw_c4_busy", 32'(busy_mask), 32'h0020);
    tick(); #1;
    chk("sw_second_write_clears", 32'(busy_mask), 32'h0000);

    // ---------------- write to a non-busy register, claim elsewhere ----------------
    mem_valid = 1'b1; mem_addr = 4'h9; mem_data = 16'h0909;
    claim_valid = 1'b1; claim_addr = 4'hC;
    tick();
    mem_valid = 1'b0; claim_valid = 1'b0; #1;
    chk("nb_claim_busy", 32'(busy_mask), 32'h1000);
    chk("nb_wr_addr",    32'(rf_wr_addr), 32'h9);
    tick(); #1;
    chk("nb_after_write_busy", 32'(busy_mask), 32'h1000);

    // ---------------- reset in the middle of traffic ----------------
    mem_valid = 1'b1; mem_addr = 4'hA; mem_data = 16'h1234; #1;
    chk("mid_mem_ready", 32'(mem_ready), 32'd1);
    tick();
    reset = 1'b1; mem_addr = 4'hB; mem_data = 16'hBBBB; #1;
    chk("mid_rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("mid_rst_wr_en",     32'(rf_wr_en), 32'd1);
    chk("mid_rst_wr_addr",   32'(rf_wr_addr), 32'hA);
    tick();
    reset = 1'b0; mem_valid = 1'b0; #1;
    chk("post_rst_wr_en",   32'(rf_wr_en), 32'd0);
    chk("post_rst_wr_addr", 32'(rf_wr_addr), 32'h0);
    chk("post_rst_wr_data", 32'(rf_wr_data), 32'h0);
    chk("post_rst_busy",    32'(busy_mask), 32'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
